// File: rtl/neuron_seq_if.sv
// Handshake and operand bus between the neuron sequencer (master) and its surroundings (slave).
// Optional abort input is present only when NEURON_SEQ_ABORT_EN is defined.
interface neuron_seq_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 6
);
  logic          start;
  logic          hidden_in;
  logic [DW-1:0] bias_in;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_value;
  logic [DW-1:0] mem_weight;
  logic [DW-1:0] value;
  logic [DW-1:0] weight;
  logic [DW-1:0] bias;
  logic          acc_clr;
  logic          ld;
  logic          hidden;
  logic          ready;
  logic [DW-1:0] result_in;
  logic [DW-1:0] result;
  logic          busy;
  logic          done;
`ifdef NEURON_SEQ_ABORT_EN
  logic          abort;
`endif

  modport master (
    input  start, hidden_in, bias_in, mem_value, mem_weight, result_in,
`ifdef NEURON_SEQ_ABORT_EN
    input  abort,
`endif
    output mem_addr, value, weight, bias, acc_clr, ld, hidden, ready, result, busy, done
  );

  modport slave (
    output start, hidden_in, bias_in, mem_value, mem_weight, result_in,
`ifdef NEURON_SEQ_ABORT_EN
    output abort,
`endif
    input  mem_addr, value, weight, bias, acc_clr, ld, hidden, ready, result, busy, done
  );
endinterface

// File: rtl/neuron_sequencer.sv
// Operand-fetch and control sequencer feeding the neuron datapath (IDLE/CLR/ACC/ACT/OUT).
// Optional feature macro: NEURON_SEQ_ABORT_EN adds an abort input that returns to IDLE.
module neuron_sequencer #(
  parameter int unsigned DW   = 8,
  parameter int unsigned N_IN = 62,
  parameter int unsigned AW   = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  neuron_seq_if.master io_bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ACC, S_ACT, S_OUT} state_t;

  localparam logic [AW-1:0] K_LAST = AW'(N_IN - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_k, w_k_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_bias, w_bias_nxt;
  logic [DW-1:0] r_result, w_result_nxt;
  logic          r_hidden, w_hidden_nxt;
  logic          r_acc_clr, w_acc_clr_nxt;
  logic          r_ld, w_ld_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_done, w_done_nxt;
  logic          r_busy, w_busy_nxt;
  logic          w_abort;
  logic          w_start_ok;

`ifdef NEURON_SEQ_ABORT_EN
  assign w_abort    = io_bus.abort & (r_state != S_IDLE);
  assign w_start_ok = io_bus.start & ~io_bus.abort;
`else
  assign w_abort    = 1'b0;
  assign w_start_ok = io_bus.start;
`endif

  // Next state plus next values of every registered output, decoded from the next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_bias_nxt     = r_bias;
    w_hidden_nxt   = r_hidden;
    w_result_nxt   = r_result;
    w_mem_addr_nxt = '0;

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt  = S_CLR;
          w_k_nxt      = '0;
          w_bias_nxt   = io_bus.bias_in;
          w_hidden_nxt = io_bus.hidden_in;
        end
      end
      S_CLR: begin
        w_state_nxt = S_ACC;
        w_k_nxt     = '0;
      end
      S_ACC: begin
        if (r_k == K_LAST) begin
          w_state_nxt = S_ACT;
        end else begin
          w_k_nxt = r_k + AW'(1);
        end
      end
      S_ACT: begin
        w_state_nxt  = S_OUT;
        w_result_nxt = io_bus.result_in;
      end
      S_OUT: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
      end
    endcase

    if (w_abort) begin
      w_state_nxt  = S_IDLE;
      w_k_nxt      = '0;
      w_result_nxt = r_result;
    end

    w_acc_clr_nxt = (w_state_nxt == S_CLR);
    w_ld_nxt      = (w_state_nxt == S_ACC);
    w_ready_nxt   = (w_state_nxt == S_ACT);
    w_done_nxt    = (w_state_nxt == S_OUT);
    w_busy_nxt    = (w_state_nxt != S_IDLE);

    // Address runs one ahead of k so returned data lines up with ld; clamps at the last pair.
    case (w_state_nxt)
      S_CLR:        w_mem_addr_nxt = '0;
      S_ACC:        w_mem_addr_nxt = (w_k_nxt == K_LAST) ? K_LAST : (w_k_nxt + AW'(1));
      S_ACT, S_OUT: w_mem_addr_nxt = r_mem_addr;
      default:      w_mem_addr_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_mem_addr <= '0;
      r_bias     <= '0;
      r_hidden   <= 1'b0;
      r_result   <= '0;
      r_acc_clr  <= 1'b0;
      r_ld       <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_bias     <= w_bias_nxt;
      r_hidden   <= w_hidden_nxt;
      r_result   <= w_result_nxt;
      r_acc_clr  <= w_acc_clr_nxt;
      r_ld       <= w_ld_nxt;
      r_ready    <= w_ready_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Operands pass straight from memory so they align with the registered ld strobe.
  assign io_bus.value    = r_ld ? io_bus.mem_value  : '0;
  assign io_bus.weight   = r_ld ? io_bus.mem_weight : '0;
  assign io_bus.mem_addr = r_mem_addr;
  assign io_bus.bias     = r_bias;
  assign io_bus.hidden   = r_hidden;
  assign io_bus.result   = r_result;
  assign io_bus.acc_clr  = r_acc_clr;
  assign io_bus.ld       = r_ld;
  assign io_bus.ready    = r_ready;
  assign io_bus.done     = r_done;
  assign io_bus.busy     = r_busy;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer: table-driven runs, operand/result scoreboard,
// reset mid-ACC, back-to-back starts and (with NEURON_SEQ_ABORT_EN) abort mid-ACC.
module tb_neuron_sequencer;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 12;
  localparam int unsigned AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_seq_if #(.DW(DW), .AW(AW)) u_if ();

  neuron_sequencer #(.DW(DW), .N_IN(N), .AW(AW)) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (u_if.master)
  );

  typedef struct {
    logic [7:0] bias;
    logic       hidden;
    logic [7:0] res;
    logic [7:0] vbase;
    logic [7:0] wbase;
    logic [7:0] wstep;
    bit         poke;
    bit         hold;
  } vec_t;

  vec_t        vecs[4];
  logic [7:0]  mem_v[16];
  logic [7:0]  mem_w[16];
  logic [15:0] q_ops[$];
  logic [7:0]  q_res[$];
  logic [7:0]  exp_bias;
  logic [7:0]  exp_result;
  logic        exp_hidden;
  int          n_checks;
  int          n_errs;

  // Synchronous-read operand memory, one cycle latency.
  always @(posedge clk) begin
    u_if.mem_value  <= mem_v[u_if.mem_addr];
    u_if.mem_weight <= mem_w[u_if.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_acc_clr", 32'(u_if.acc_clr), 32'(0));
    chk("rst_ld",      32'(u_if.ld),      32'(0));
    chk("rst_ready",   32'(u_if.ready),   32'(0));
    chk("rst_done",    32'(u_if.done),    32'(0));
    chk("rst_busy",    32'(u_if.busy),    32'(0));
    chk("rst_value",   32'(u_if.value),   32'(0));
    chk("rst_weight",  32'(u_if.weight),  32'(0));
    chk("rst_bias",    32'(u_if.bias),    32'(0));
    chk("rst_hidden",  32'(u_if.hidden),  32'(0));
    chk("rst_result",  32'(u_if.result),  32'(0));
    chk("rst_addr",    32'(u_if.mem_addr), 32'(0));
  endtask

  // Scoreboard: operands popped on every ld cycle, result popped on done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.ld) begin
        chk("ops_avail", 32'(q_ops.size() != 0), 32'(1));
        if (q_ops.size() != 0) begin
          logic [15:0] e;
          e = q_ops.pop_front();
          chk("value",  32'(u_if.value),  32'(e[15:8]));
          chk("weight", 32'(u_if.weight), 32'(e[7:0]));
        end
      end else begin
        chk("operands_zero", 32'({u_if.value, u_if.weight}), 32'(0));
      end
      if (u_if.done) begin
        chk("res_avail", 32'(q_res.size() != 0), 32'(1));
        if (q_res.size() != 0) chk("result", 32'(u_if.result), 32'(q_res.pop_front()));
      end
    end
  end

  // One computation; kill_c > 0 ends it at that cycle by reset or abort.
  task automatic run(input vec_t v, input int kill_c, input bit kill_abort);
    int ea;
    @(negedge clk);
    chk("idle_busy",   32'(u_if.busy),   32'(0));
    chk("idle_done",   32'(u_if.done),   32'(0));
    chk("idle_bias",   32'(u_if.bias),   32'(exp_bias));
    chk("idle_hidden", 32'(u_if.hidden), 32'(exp_hidden));
    chk("idle_result", 32'(u_if.result), 32'(exp_result));
    for (int k = 0; k < 16; k++) begin
      if (k < int'(N)) begin
        mem_v[k] = v.vbase + 8'(k);
        mem_w[k] = v.wbase + 8'(k) * v.wstep;
        q_ops.push_back({mem_v[k], mem_w[k]});
      end else begin
        mem_v[k] = 8'hEE;
        mem_w[k] = 8'hEE;
      end
    end
    q_res.push_back(v.res);
    u_if.bias_in   = v.bias;
    u_if.hidden_in = v.hidden;
    u_if.start     = 1'b1;
    exp_bias       = v.bias;
    exp_hidden     = v.hidden;
    for (int c = 1; c <= int'(N) + 3; c++) begin
      @(negedge clk);
      if (c == kill_c) begin
        u_if.start = 1'b0;
        if (kill_abort) begin
`ifdef NEURON_SEQ_ABORT_EN
          u_if.abort = 1'b1;
          @(negedge clk);
          u_if.abort = 1'b0;
          q_ops.delete();
          q_res.delete();
          chk("abort_busy",   32'(u_if.busy),   32'(0));
          chk("abort_ld",     32'(u_if.ld),     32'(0));
          chk("abort_done",   32'(u_if.done),   32'(0));
          chk("abort_result", 32'(u_if.result), 32'(exp_result));
`endif
        end else begin
          #2 rst_n = 1'b0;
          #1 chk_reset_state();
          q_ops.delete();
          q_res.delete();
          exp_bias   = '0;
          exp_hidden = 1'b0;
          exp_result = '0;
          @(negedge clk);
          rst_n = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("kill_no_done", 32'(u_if.done), 32'(0));
          chk("kill_idle",    32'(u_if.busy), 32'(0));
        end
        return;
      end
      chk("acc_clr", 32'(u_if.acc_clr), 32'(c == 1));
      chk("ld",      32'(u_if.ld),      32'(c >= 2 && c <= int'(N) + 1));
      chk("ready",   32'(u_if.ready),   32'(c == int'(N) + 2));
      chk("done",    32'(u_if.done),    32'(c == int'(N) + 3));
      chk("busy",    32'(u_if.busy),    32'(1));
      chk("bias",    32'(u_if.bias),    32'(v.bias));
      chk("hidden",  32'(u_if.hidden),  32'(v.hidden));
      if (c <= int'(N) + 1) begin
        ea = (c == 1) ? 0 : ((c - 1 > int'(N) - 1) ? int'(N) - 1 : c - 1);
        chk("mem_addr", 32'(u_if.mem_addr), 32'(ea));
      end
      u_if.start = v.hold | (v.poke & (c == 5 || c == int'(N) + 2));
      if (v.poke && c == 3) begin
        u_if.bias_in   = 8'h00;
        u_if.hidden_in = 1'b0;
      end
      if (c == int'(N) + 1) u_if.result_in = v.res;
      if (c == int'(N) + 3) u_if.result_in = 8'h00;
    end
    exp_result = v.res;
  endtask

  initial begin
    n_checks       = 0;
    n_errs         = 0;
    exp_bias       = '0;
    exp_hidden     = 1'b0;
    exp_result     = '0;
    u_if.start     = 1'b0;
    u_if.hidden_in = 1'b0;
    u_if.bias_in   = '0;
    u_if.result_in = '0;
`ifdef NEURON_SEQ_ABORT_EN
    u_if.abort     = 1'b0;
`endif
    for (int k = 0; k < 16; k++) begin
      mem_v[k] = '0;
      mem_w[k] = '0;
    end
    vecs[0] = '{8'h15, 1'b1, 8'h7F, 8'h01, 8'h02, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 8'h00, 8'h80, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 8'h81, 8'hF8, 8'h00, 8'h11, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 8'h3C, 8'h10, 8'h33, 8'h05, 1'b0, 1'b0};

    #12 chk_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run(vecs[i], 0, 1'b0);

    // Result must stay put in IDLE while result_in is zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_result", 32'(u_if.result), 32'(exp_result));
      chk("hold_done",   32'(u_if.done),   32'(0));
    end

    run(vecs[0], 12, 1'b0);
    run(vecs[1], 0, 1'b0);
    run(vecs[3], 0, 1'b0);
`ifdef NEURON_SEQ_ABORT_EN
    run(vecs[2], 4, 1'b1);
    run(vecs[0], 0, 1'b0);
`endif

    @(negedge clk);
    chk("ops_drained", 32'(q_ops.size()), 32'(0));
    chk("res_drained", 32'(q_res.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/neuron_sequencer.md
# neuron_sequencer

Control and operand-fetch stage directly upstream of the neuron datapath. On `start` it walks a synchronous-read operand memory over `N_IN` input/weight pairs, presents each pair to the datapath with an aligned `ld` strobe, holds the neuron bias and the hidden-layer mode stable for the whole computation, pulses `ready` to the activation stage, and captures the activated result into an output register flagged by `done`.

## Interface
- `DW`, 8, operand width (value, weight, bias, result)
- `N_IN`, 62, number of input/weight pairs per neuron (≥1)
- `AW`, 6, operand address width; must satisfy 2^AW ≥ `N_IN`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin one neuron computation; sampled only in IDLE
- `hidden_in`  in  1  layer mode, latched at start accept
- `bias_in`  in  DW  neuron bias, latched at start accept
- `mem_addr`  out  AW  operand memory address (memory returns data one cycle later)
- `mem_value`  in  DW  input value read from memory
- `mem_weight`  in  DW  weight read from memory
- `value`, `weight`  out  DW  operands to datapath; zero whenever `ld`=0
- `bias`  out  DW  latched bias to datapath
- `acc_clr`  out  1  clears datapath accumulator
- `ld`  out  1  datapath accumulate enable
- `hidden`  out  1  latched layer mode to datapath
- `ready`  out  1  activation evaluate strobe
- `result_in`  in  DW  activated result from datapath
- `result`  out  DW  captured result
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse, `result` valid

## Operation
- States: IDLE, CLR, ACC, ACT, OUT.
- IDLE: `start`=1 → CLR; latch `bias_in`→`bias`, `hidden_in`→`hidden`; counter k←0.
- CLR (1 cycle): `acc_clr`=1, `mem_addr`=0.
- ACC (`N_IN` cycles, k=0..N_IN-1): `ld`=1; `value`/`weight` = `mem_value`/`mem_weight` (data for address k); `mem_addr`=min(k+1, N_IN-1). k=N_IN-1 → ACT, else k←k+1.
- ACT (1 cycle): `ready`=1; `result`←`result_in` at end of cycle.
- OUT (1 cycle): `done`=1 → IDLE.
- Counter never addresses beyond N_IN-1; no wrap to 0 inside a computation.
- `start` outside IDLE is ignored (not queued). `start` held high in OUT → new computation begins at the cycle after OUT returns to IDLE.
- `bias`, `hidden`, `result` hold their values in IDLE until overwritten.
- `N_IN`=1: ACC lasts exactly one cycle.

## Timing
- Reset (`rst`=0, any state, immediate): state=IDLE, k=0, `mem_addr`=0, `bias`=0, `hidden`=0, `result`=0, `acc_clr`=`ld`=`ready`=`done`=`busy`=0, `value`=`weight`=0. Reset mid-computation aborts without `done`.
- All control outputs are decoded from registered state; no combinational path from `start` to outputs.
- Start accepted at edge E0 → CLR in cycle 1, ACC cycles 2..N_IN+1, ACT cycle N_IN+2, `done` cycle N_IN+3. Start-to-done latency = N_IN+3 cycles; earliest next start accept = cycle N_IN+4.
- Operand memory latency is exactly one cycle; `ld` is aligned to returned data, not to the address.

## Configuration
- `NEURON_SEQ_ABORT_EN` defined: adds input `abort` (1 bit). `abort`=1 in any non-IDLE state → IDLE next cycle, `done` not asserted, `result` unchanged, `acc_clr`/`ld`/`ready` deasserted immediately. `abort` and `start` together in IDLE → start ignored.
- Not defined: no `abort` port; every accepted computation runs to `done`.

## Test plan
- Reset mid-ACC (k=10): all outputs at reset values immediately; no `done`; next `start` runs full N_IN+3 sequence.
- N_IN=4, memory value=k+1, weight=2: `ld` high cycles 2–5 with `value` 1,2,3,4 and `weight` 2; `mem_addr` sequence 0,1,2,3,3; `ready` cycle 6; `done` cycle 7.
- `bias_in`=0x15, `hidden_in`=1 at start, then changed to 0x00/0 during ACC: `bias`=0x15 and `hidden`=1 held through OUT.
- `start` pulsed during ACC and ACT: ignored, single `done`; `start` held continuously: back-to-back computations with exactly one IDLE cycle between OUT and CLR.
- `result_in`=0x7F during ACT, 0x00 afterwards: `result`=0x7F from `done` cycle onward, held in IDLE.
- With `NEURON_SEQ_ABORT_EN`: `abort` in ACC at k=2 → IDLE next cycle, no `done`, `result` keeps previous value.
